// File: rtl/mult_pkg.sv
// Shared encodings and types for the RV32M multiply issue controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: RV32M opcode/funct7/funct3 constants, controller state enum, and
// the multiplier mode struct {sigA, sigB, upper}.
package mult_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    typedef struct packed {
        logic sig_a;
        logic sig_b;
        logic upper;
    } mult_mode_t;

endpackage

// File: rtl/mult_decode.sv
// Combinational decode of an RV32M multiply: match flag plus operand signedness/half select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies match_o with valid/ready.
// Ports: opcode_i/funct3_i/funct7_i instruction fields in; match_o set for
// MUL/MULH/MULHSU/MULHU only (divide/remainder have funct3[2]=1); mode_o mode bits.
module mult_decode
    import mult_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    output logic        match_o,
    output mult_mode_t  mode_o
);

    always_comb begin
        match_o = (opcode_i == OPCODE_OP) && (funct7_i == FUNCT7_MULDIV) && !funct3_i[2];
        mode_o  = '{sig_a: 1'b1, sig_b: 1'b1, upper: 1'b0};
        unique case (funct3_i)
            F3_MUL:    mode_o = '{sig_a: 1'b1, sig_b: 1'b1, upper: 1'b0};
            F3_MULH:   mode_o = '{sig_a: 1'b1, sig_b: 1'b1, upper: 1'b1};
            F3_MULHSU: mode_o = '{sig_a: 1'b1, sig_b: 1'b0, upper: 1'b1};
            F3_MULHU:  mode_o = '{sig_a: 1'b0, sig_b: 1'b0, upper: 1'b1};
            default:   mode_o = '{sig_a: 1'b1, sig_b: 1'b1, upper: 1'b0};
        endcase
    end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/complete controller in front of a fixed-latency multiplier: latches operands and mode, waits STAGES cycles, captures the result.
// Latency: accept edge to done_o high is STAGES+1 edges counting the accept edge (1 edge in zero bypass).
// Backpressure: ready_o low while BUSY; a new op may be accepted in the DONE cycle.
// Ports: clk, rst (sync, active-low); valid_i/opcode_i/funct3_i/funct7_i/rs1_i/rs2_i
// instruction in; ready_o; A_o/B_o/sigA_o/sigB_o/upper_o/mult_on_o to the multiplier;
// writeback_value_i from the multiplier; busy_o, done_o (1-cycle pulse), result_o (held).
// Option: define MULT_ZERO_BYPASS_EN to complete ops with a zero operand in one cycle with result 0.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] A_o,
    output logic [WIDTH-1:0] B_o,
    output logic             sigA_o,
    output logic             sigB_o,
    output logic             upper_o,
    output logic             mult_on_o,
    input  logic [WIDTH-1:0] writeback_value_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int            CW       = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(STAGES - 1);

    mult_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    mult_mode_t       mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             dec_match;
    mult_mode_t       dec_mode;
    logic             accept;
    logic             bypass;

    mult_decode u_decode (
        .opcode_i (opcode_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .match_o  (dec_match),
        .mode_o   (dec_mode)
    );

`ifdef MULT_ZERO_BYPASS_EN
    // Product is known to be zero; no need to occupy the multiplier.
    assign bypass = (rs1_i == '0) || (rs2_i == '0);
`else
    assign bypass = 1'b0;
`endif

    // Outputs are pure functions of registered state.
    assign ready_o   = (state_q != BUSY);
    assign busy_o    = (state_q == BUSY);
    assign mult_on_o = (state_q == BUSY);
    assign done_o    = (state_q == DONE);
    assign A_o       = a_q;
    assign B_o       = b_q;
    assign sigA_o    = mode_q.sig_a;
    assign sigB_o    = mode_q.sig_b;
    assign upper_o   = mode_q.upper;
    assign result_o  = result_q;

    assign accept = valid_i && ready_o && dec_match;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        result_d = result_q;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE falls back to IDLE unless a new op launches in the same cycle.
                state_d = IDLE;
                if (accept) begin
                    a_d    = rs1_i;
                    b_d    = rs2_i;
                    mode_d = dec_mode;
                    cnt_d  = CNT_INIT;
                    if (bypass) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                // Counter reaches 0 in the STAGES-th BUSY cycle, when the
                // multiplier output becomes valid.
                if (cnt_q == '0) begin
                    result_d = writeback_value_i;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Sequential issue/complete controller directly upstream of the multiplier datapath in the RV32M accelerator. It decodes RV32M multiply instructions and latches the operands. It drives the multiplier operand and mode inputs for a fixed STAGES-cycle latency, then captures the writeback value and signals completion. Only MUL/MULH/MULHSU/MULHU are handled; divide/remainder encodings are ignored.

Parameters:
WIDTH, 32, operand/result width
STAGES, 7, multiplier latency in cycles from mult_on_o rise to valid writeback_value_i (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-low reset
valid_i  input  1  instruction/operands valid
opcode_i  input  7  instruction opcode field
funct3_i  input  3  instruction funct3 field
funct7_i  input  7  instruction funct7 field
rs1_i  input  WIDTH  source operand 1
rs2_i  input  WIDTH  source operand 2
ready_o  output  1  controller can accept an instruction
A_o  output  WIDTH  latched rs1 to multiplier
B_o  output  WIDTH  latched rs2 to multiplier
sigA_o  output  1  treat A as signed
sigB_o  output  1  treat B as signed
upper_o  output  1  select upper half of 2*WIDTH product
mult_on_o  output  1  multiplier operation in progress
writeback_value_i  input  WIDTH  result from multiplier
busy_o  output  1  operation in flight
done_o  output  1  one-cycle completion pulse
result_o  output  WIDTH  captured result, held until next capture

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs 0 except ready_o=1; counter 0. Reset mid-operation aborts; no done_o.
- Match: opcode_i==7'b0110011 && funct7_i==7'b0000001 && funct3_i[2]==0. Accept = valid_i && ready_o && match. Non-matching valid_i: ignored, no state change.
- Decode on accept (funct3 -> sigA,sigB,upper): 000 MUL 1,1,0; 001 MULH 1,1,1; 010 MULHSU 1,0,1; 011 MULHU 0,0,1.
- States: IDLE, BUSY, DONE.
- IDLE: ready_o=1. On accept, latch rs1/rs2 into A_o/B_o and the decoded mode bits; counter=STAGES-1; go BUSY.
- BUSY: ready_o=0, busy_o=1, mult_on_o=1; A_o/B_o/mode held stable. Counter decrements each cycle. When counter==0, capture writeback_value_i into result_o and go DONE. Latency: accept edge to done_o high = STAGES+1 edges.
- DONE: done_o=1 (exactly one cycle), mult_on_o=0, ready_o=1. On accept in the same cycle, launch the new op (-> BUSY) while done_o still reports the old result. Otherwise go IDLE.
- result_o changes only on capture. A_o/B_o keep the last operands when idle.
- STAGES=1: BUSY lasts one cycle.

Optional Feature:
MULT_ZERO_BYPASS_EN. Defined: on accept with rs1_i==0 or rs2_i==0, skip BUSY and go to DONE next cycle with result_o=0. mult_on_o is never asserted; A_o/B_o are still latched. Undefined: zero operands take the normal STAGES path.

Decomposition:
- Package mult_pkg: OPCODE_OP (7'b0110011), FUNCT7_MULDIV (7'b0000001), funct3 localparams F3_MUL/F3_MULH/F3_MULHSU/F3_MULHU, state enum typedef mult_state_t {IDLE,BUSY,DONE}, packed struct mult_mode_t {sigA,sigB,upper}.
- Sub-module mult_decode: combinational, {opcode,funct3,funct7} -> match, mult_mode_t. The FSM/counter stays in mult_issue_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles with valid_i=1 -> ready_o=1, done_o=0, result_o=0, mult_on_o=0.
- MUL, rs1=0x00000009, rs2=0x00000007; model returns 0x0000003F after 7 cycles -> A_o=9, B_o=7, sigA/sigB/upper=1/1/0, mult_on_o high for 7 cycles, done_o pulse 8 edges after accept, result_o=0x0000003F.
- Mode decode: MULH, MULHSU, MULHU with rs1=0x80000001, rs2=0x80010002 -> modes 1/1/1, 1/0/1, 0/0/1; A_o/B_o stable throughout BUSY.
- Ignored encodings: DIV (funct3=100) and funct7=0 ADD with valid_i=1 -> no accept, ready_o stays 1, no mult_on_o.
- Back-to-back: new MUL (rs1=0x00a03009, rs2=0x00000107) presented during DONE -> accepted same cycle, old result_o seen with done_o, then 0xA491593F after STAGES.
- Reset mid-BUSY at cycle 3 -> IDLE next edge, no done_o. With MULT_ZERO_BYPASS_EN, rs2=0 -> done_o one cycle after accept, result_o=0.
